imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the core's instruction memory from a byte stream and holds the core in reset until the image is complete and verified. It accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words. It drives a one-word-per-pulse write port into instruction memory and releases `core_rst` only after a good checksum. It sits beside the core top level, ahead of the instruction memory write side, on the same clock.

## Interface
- `DEPTH`, 64: instruction memory capacity in 32-bit words; maximum accepted image length.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Honoured in IDLE, DONE and ERROR; ignored otherwise.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle. A byte transfers on an edge where `byte_valid && byte_ready`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of the word being written, word aligned.
- `mem_wdata`  out  32  word being written.
- `core_rst`  out  1  hold-reset to the core, high except in DONE.
- `done`  out  1  image loaded and checksum matched.
- `err`  out  1  load failed on bad length or bad checksum.

## Operation
- Stream format:
  - 2 length bytes giving N as a 16-bit value, low byte first.
  - 4·N payload bytes, with each word sent low byte first.
  - 1 checksum byte equal to the XOR of all payload bytes.
- States: IDLE, LEN, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE → LEN on `start`. Entering LEN does the following:
  - clears `done`, `err`, the byte counter, the word index and the running XOR;
  - sets `core_rst`=1.
- LEN: `byte_ready`=1. The first accepted byte is N[7:0] and the second is N[15:0]'s upper byte.
  - After the second byte: go to ERROR if N==0 or N>DEPTH, otherwise go to DATA.
- DATA: `byte_ready`=1.
  - Each accepted byte is placed at lane (byte count mod 4) of the word buffer and XORed into the checksum.
  - On the 4th byte, go to WRITE.
- WRITE: `byte_ready`=0, `mem_we`=1 for exactly this cycle.
  - `mem_addr` = word_idx·4 and `mem_wdata` = the assembled word.
  - Next state is CHECK if word_idx==N−1; otherwise DATA with word_idx+1.
- CHECK: `byte_ready`=1. On the accepted byte:
  - equal to the running XOR → DONE;
  - not equal → ERROR.
- DONE: `done`=1, `core_rst`=0, `byte_ready`=0.
- ERROR: `err`=1, `core_rst`=1, `byte_ready`=0.
  - Words already written are not undone.
- `start` is honoured only in IDLE, DONE and ERROR. Each of these transitions to LEN and clears `done`/`err` on the same edge.
- `start` in LEN, DATA, WRITE or CHECK is ignored.
- `byte_valid` without `byte_ready` has no effect, and bytes are never dropped or duplicated. `byte_in` is sampled only on a transfer edge.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE. `mem_we` is 0 everywhere except WRITE.

## Timing
- Reset values (all outputs): state IDLE; `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst`=1, `done`=0, `err`=0.
- Reset mid-load aborts immediately to these values. A later `start` begins a fresh load.
- `byte_ready` is a combinational decode of the state register.
- All other outputs are registered.
- With `start` at edge k, LEN is active from cycle k+1.
- Each word costs 4 transfer cycles plus 1 WRITE cycle.
- With `byte_valid` held high, the checksum transfer occurs at edge k+2+5N+1. `done`, or `err`, and the `core_rst` change are visible in the next cycle.
- The length error is visible in the cycle after the second length byte, with no `mem_we` ever asserted.
- Stalls on `byte_valid` extend timing cycle-for-cycle and leave results unchanged.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs at reset values; `byte_ready`=0 until `start`.
- **Nominal load:** `start`, then bytes 02 00 13 00 00 00 93 00 10 00 90 with `byte_valid` held high. Required response:
  - `mem_we` pulses at addr 0x0 with data 0x00000013;
  - `mem_we` pulses at addr 0x4 with data 0x00100093;
  - `done`=1 and `core_rst`=0 one cycle after the 0x90 transfer.
- **Stalled stream:** same image with `byte_valid` high every other cycle → identical writes and final state.
- **Bad checksum:** same image with checksum 0x91 → both writes occur, then `err`=1, `core_rst`=1, `done`=0.
- **Bad length:**
  - length bytes 00 00 → ERROR with no `mem_we`;
  - length DEPTH+1 (41 00 for DEPTH=64) → ERROR with no `mem_we`.
- **Abort and restart:**
  - `start` pulsed mid-DATA → ignored;
  - `rst` after 3 payload bytes → reset values;
  - then a fresh nominal load → DONE with correct writes starting at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed, XOR-checked image into instruction
// memory and holds the core in reset until the image verifies.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] buf_q, buf_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer;
    logic [15:0] n_full;

    assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA)
                     || (state_q == S_CHECK);
    assign xfer   = byte_valid && byte_ready;
    assign n_full = {byte_in, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        buf_d       = buf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_rst_d  = core_rst_q;
        done_d      = done_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN;
                    cnt_d      = 2'd0;
                    idx_d      = 16'd0;
                    csum_d     = 8'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    core_rst_d = 1'b1;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (cnt_q == 2'd0) begin
                        len_d[7:0] = byte_in;
                        cnt_d      = 2'd1;
                    end else begin
                        len_d[15:8] = byte_in;
                        cnt_d       = 2'd0;
                        if (n_full == 16'd0 || n_full > DEPTH_W) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = byte_in;
                    csum_d = csum_q ^ byte_in;
                    cnt_d  = cnt_q + 2'd1;
                    // Launch the write with the fourth byte merged in directly.
                    if (cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {14'd0, idx_q, 2'b00};
                        mem_wdata_d = {byte_in, buf_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == len_q - 16'd1) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (byte_in == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            csum_q      <= 8'd0;
            buf_q       <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            buf_q       <= buf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vector table, abort/restart sequence and
// randomized images checked against a stream-level reference model.
module tb_imem_loader;

    localparam int DEPTH = 64;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  b [0:10];
        int          nb;
        int          mode;
        logic        exp_done;
        logic        exp_err;
        int          exp_nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [63:0] wq[$];

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, ".ready"}, byte_ready, 0);
        chk({nm, ".we"}, mem_we, 0);
        chk({nm, ".addr"}, mem_addr, 0);
        chk({nm, ".wdata"}, mem_wdata, 0);
        chk({nm, ".core_rst"}, core_rst, 1);
        chk({nm, ".done"}, done, 0);
        chk({nm, ".err"}, err, 0);
    endtask

    // mode 0: always valid, 1: every other cycle, 2: random
    task automatic run(input bq_t s, input int mode, output int cyc);
        int i;
        int budget;
        logic v;
        logic x;
        i = 0;
        budget = 0;
        wq.delete();
        do_start();
        while (i < s.size() && budget < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = budget[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_in    = v ? s[i] : 8'($urandom);
            x = v && byte_ready;
            tick();
            budget++;
            if (x) i++;
        end
        byte_valid = 1'b0;
        cyc = budget;
        if (i < s.size()) chk("stream_timeout", i, s.size());
    endtask

    // Reference: decode the stream and compare all end-of-load observables.
    task automatic check_model(input string nm, input bq_t s,
                               input int mode, input int cyc);
        int n;
        logic lenbad;
        logic [7:0] x;
        logic [31:0] w;
        logic good;
        n = int'({s[1], s[0]});
        lenbad = (n == 0) || (n > DEPTH);
        x = 8'd0;
        good = 1'b0;
        if (lenbad) begin
            chk({nm, ".nw"}, wq.size(), 0);
            if (mode == 0) chk({nm, ".lat"}, cyc, 2);
        end else begin
            chk({nm, ".nw"}, wq.size(), n);
            for (int k = 0; k < n; k++) begin
                w = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
                x = x ^ s[2+4*k] ^ s[2+4*k+1] ^ s[2+4*k+2] ^ s[2+4*k+3];
                if (k < wq.size())
                    chk({nm, ".w"}, wq[k], {32'(4 * k), w});
            end
            good = (s[2+4*n] == x);
            if (mode == 0) chk({nm, ".lat"}, cyc, 3 + 5 * n);
        end
        chk({nm, ".done"}, done, !lenbad && good);
        chk({nm, ".err"}, err, lenbad || !good);
        chk({nm, ".core_rst"}, core_rst, lenbad || !good);
        chk({nm, ".ready"}, byte_ready, 0);
        chk({nm, ".we"}, mem_we, 0);
    endtask

    vec_t tv[5];
    logic [7:0] nom [0:10];
    logic [7:0] zb  [0:10];
    bq_t q;
    int cyc;

    initial begin
        nom = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        foreach (zb[i]) zb[i] = 8'h00;
        tv[0] = '{b:nom, nb:11, mode:0, exp_done:1, exp_err:0, exp_nw:2,
                  w0:32'h00000013, w1:32'h00100093};
        tv[1] = tv[0];
        tv[1].mode = 1;
        tv[2] = tv[0];
        tv[2].b[10] = 8'h91;
        tv[2].exp_done = 0;
        tv[2].exp_err = 1;
        tv[3] = '{b:zb, nb:2, mode:0, exp_done:0, exp_err:1, exp_nw:0,
                  w0:32'h0, w1:32'h0};
        tv[4] = tv[3];
        tv[4].b[0] = 8'h41;

        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        byte_valid = 1'b1;
        tick();
        tick();
        chk("idle.ready", byte_ready, 0);
        chk("idle.core_rst", core_rst, 1);
        byte_valid = 1'b0;

        for (int t = 0; t < 5; t++) begin
            q.delete();
            for (int j = 0; j < tv[t].nb; j++) q.push_back(tv[t].b[j]);
            run(q, tv[t].mode, cyc);
            chk($sformatf("v%0d.nw", t), wq.size(), tv[t].exp_nw);
            if (tv[t].exp_nw == 2 && wq.size() == 2) begin
                chk($sformatf("v%0d.w0", t), wq[0], {32'h0, tv[t].w0});
                chk($sformatf("v%0d.w1", t), wq[1], {32'h4, tv[t].w1});
            end
            chk($sformatf("v%0d.done", t), done, tv[t].exp_done);
            chk($sformatf("v%0d.err", t), err, tv[t].exp_err);
            chk($sformatf("v%0d.core_rst", t), core_rst, !tv[t].exp_done);
            chk($sformatf("v%0d.ready", t), byte_ready, 0);
            if (tv[t].mode == 0)
                chk($sformatf("v%0d.lat", t), cyc,
                    tv[t].nb == 2 ? 2 : 13);
        end

        // Abort: ignored start mid-DATA, then reset after 3 payload bytes.
        wq.delete();
        do_start();
        chk("abort.cleared_err", err, 0);
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            byte_in = nom[i];
            start = (i == 3);
            tick();
        end
        byte_valid = 1'b0;
        start = 1'b0;
        chk("abort.start_ignored_err", err, 0);
        chk("abort.in_data_ready", byte_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("abort.rst");
        chk("abort.nw", wq.size(), 0);
        q.delete();
        for (int j = 0; j < 11; j++) q.push_back(nom[j]);
        run(q, 0, cyc);
        check_model("restart", q, 0, cyc);
        chk("restart.w0", wq.size() > 0 ? wq[0] : 64'hx, 64'h13);

        for (int r = 0; r < 20; r++) begin
            int n;
            int sel;
            int md;
            logic [7:0] x;
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 0 : (sel == 1) ? DEPTH + $urandom_range(1, 40)
                                            : $urandom_range(1, 6);
            q.delete();
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            if (n >= 1 && n <= DEPTH) begin
                x = 8'h00;
                for (int j = 0; j < 4 * n; j++) begin
                    q.push_back(8'($urandom));
                    x = x ^ q[q.size() - 1];
                end
                q.push_back(($urandom_range(0, 3) == 0) ? ~x : x);
            end
            md = $urandom_range(0, 2);
            run(q, md, cyc);
            check_model($sformatf("rnd%0d", r), q, md, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
